btn_pulse_gen: RTL and testbench
================================

// Module: btn_pulse_gen
// PURPOSE
//  Debounces one raw push-button input and produces a single-clk-cycle pulse per
//  accepted press. Sits directly upstream of the clock divider/selector: its
//  'pulse' output drives the selector's manual-step input, so each button press
//  single-steps the CPU clock. Also gives the debounced level, a release strobe
//  and a press counter for the seven-segment/LED debug display.
// PARAMETERS
//  DEBOUNCE_CYCLES  1000000  consecutive stable clk cycles to accept an edge (10 ms @ 100 MHz); legal min 2
//  REPEAT_DELAY     50000000 clk cycles held in PRESSED before first auto-repeat pulse (AUTO_REPEAT_EN only)
//  REPEAT_PERIOD    10000000 clk cycles between later auto-repeat pulses (AUTO_REPEAT_EN only)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   asynchronous, active-high reset
//  btn_in         in   1   raw, asynchronous, bouncing button (1 = pressed)
//  btn_level      out  1   debounced level; 1 in PRESSED and RELEASE_WAIT
//  pulse          out  1   one-cycle strobe per accepted press (and per auto-repeat)
//  release_pulse  out  1   one-cycle strobe per accepted release
//  press_cnt      out  16  count of pulse strobes, wraps 0xFFFF -> 0x0000
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, both sync flops 0, all counters 0.
//  - Sync: btn_in -> 2-flop synchronizer -> s. FSM and counters use s only.
//  - Debounce counter width $clog2(DEBOUNCE_CYCLES+1); never wraps.
//  - FSM, all outputs registered:
//    IDLE:         s=1 -> PRESS_WAIT, cnt<=1; else stay.
//    PRESS_WAIT:   s=0 -> IDLE, cnt<=0 (bounce rejected, no strobe);
//                  s=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED, pulse<=1, press_cnt++;
//                  else cnt++.
//    PRESSED:      s=0 -> RELEASE_WAIT, cnt<=1; else stay.
//    RELEASE_WAIT: s=1 -> PRESSED, cnt<=0 (no strobe, no new press);
//                  s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, release_pulse<=1;
//                  else cnt++.
//  - Press is accepted after exactly DEBOUNCE_CYCLES consecutive s=1 samples.
//  - Latency: if edge k first captures btn_in=1 into flop 1 and btn_in stays high,
//    pulse is high for exactly the one cycle after edge k+DEBOUNCE_CYCLES+1.
//    Release latency is the same.
//  - pulse and release_pulse are never high together, and never high 2 cycles in a row.
//  - btn_level rises in the same cycle as pulse and falls in the same cycle as release_pulse.
//  - press_cnt updates in the same edge that sets pulse.
//  - Reset mid-operation: immediate return to reset values. A button held through
//    reset release is re-debounced from IDLE and then produces one pulse.
// CONFIGURATION
//  AUTO_REPEAT_EN defined:
//    - A repeat counter runs while in PRESSED, is frozen in RELEASE_WAIT and is
//      cleared when IDLE is entered.
//    - First extra pulse comes REPEAT_DELAY cycles after the press pulse.
//    - After that, one extra pulse every REPEAT_PERIOD cycles.
//    - Each extra pulse increments press_cnt.
//  AUTO_REPEAT_EN undefined:
//    - No repeat logic is built; REPEAT_* parameters are ignored.
//    - Exactly one pulse per accepted press.
// TESTING (bench uses DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
//  1. rst high 3 cycles, btn_in=0 -> all outputs 0.
//     Clean press at edge k, held -> single pulse in the cycle after edge k+5;
//     btn_level=1; press_cnt=1.
//  2. Bounce btn_in 1,0,1,1,0 one per cycle, then steady 0 -> no pulse;
//     btn_level stays 0; press_cnt stays 0.
//  3. Held press, then 1-cycle low glitch -> no release_pulse.
//     Later held low for 6 cycles -> one release_pulse; btn_level=0.
//  4. Assert rst during PRESS_WAIT (cnt=2) with btn_in held high -> outputs 0 at once.
//     After rst falls -> pulse exactly 5 edges after the first capture.
//  5. Preload press_cnt=0xFFFF via 65535 presses (or a force), one more press
//     -> press_cnt=0x0000 and pulse still asserted.
//  6. AUTO_REPEAT_EN: hold for 20 cycles after the press pulse
//     -> extra pulses at +8, +11, +14, +17, +20.
//     Without the macro -> only the press pulse.

Source files
------------

// File: rtl/btn_pulse_gen.sv
// btn_pulse_gen: push-button debouncer with a one-cycle press strobe, a release
// strobe, the debounced level and a 16-bit press counter.
// Optional build macro AUTO_REPEAT_EN adds auto-repeat pulses while the button
// is held. Without it, no repeat logic is built and REPEAT_* are ignored.
module btn_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_in,
  output logic        btn_level,
  output logic        pulse,
  output logic        release_pulse,
  output logic [15:0] press_cnt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS_WAIT,
    ST_PRESSED,
    ST_RELEASE_WAIT
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_sync1, r_sync2;
  logic          r_level, r_pulse, r_rel;
  logic [15:0]   r_press_cnt;
  logic          w_s;

  assign w_s           = r_sync2;
  assign btn_level     = r_level;
  assign pulse         = r_pulse;
  assign release_pulse = r_rel;
  assign press_cnt     = r_press_cnt;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = $clog2(RMAX + 1);

  // r_rep_armed: first repeat already issued, so later ones use REPEAT_PERIOD
  logic [RCW-1:0] r_rep;
  logic           r_rep_armed;
  logic           w_rep_hit;

  assign w_rep_hit = (r_rep == (r_rep_armed ? RCW'(REPEAT_PERIOD - 1)
                                            : RCW'(REPEAT_DELAY - 1)));
`endif

  // Two-flop synchronizer for the raw asynchronous button
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_in;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce FSM; strobes default low so they can only last one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_level     <= 1'b0;
      r_pulse     <= 1'b0;
      r_rel       <= 1'b0;
      r_press_cnt <= '0;
`ifdef AUTO_REPEAT_EN
      r_rep       <= '0;
      r_rep_armed <= 1'b0;
`endif
    end else begin
      r_pulse <= 1'b0;
      r_rel   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
`ifdef AUTO_REPEAT_EN
          // IDLE always precedes a fresh press, so the repeat timer restarts here
          r_rep       <= '0;
          r_rep_armed <= 1'b0;
`endif
          if (w_s) begin
            r_state <= ST_PRESS_WAIT;
            r_cnt   <= CW'(1);
          end
        end
        ST_PRESS_WAIT: begin
          if (!w_s) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state     <= ST_PRESSED;
            r_level     <= 1'b1;
            r_pulse     <= 1'b1;
            r_press_cnt <= r_press_cnt + 16'd1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_PRESSED: begin
          if (!w_s) begin
            r_state <= ST_RELEASE_WAIT;
            r_cnt   <= CW'(1);
          end
`ifdef AUTO_REPEAT_EN
          else if (w_rep_hit) begin
            r_pulse     <= 1'b1;
            r_press_cnt <= r_press_cnt + 16'd1;
            r_rep       <= '0;
            r_rep_armed <= 1'b1;
          end else begin
            r_rep <= r_rep + RCW'(1);
          end
`endif
        end
        ST_RELEASE_WAIT: begin
          // Repeat timer is left untouched here: a glitch resumes where it was
          if (w_s) begin
            r_state <= ST_PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_rel   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btn_pulse_gen.sv
// tb_btn_pulse_gen: directed bench for btn_pulse_gen with DEBOUNCE_CYCLES=4,
// REPEAT_DELAY=8, REPEAT_PERIOD=3. Builds with or without AUTO_REPEAT_EN.
module tb_btn_pulse_gen;
  localparam int D  = 4;
  localparam int RD = 8;
  localparam int RP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_in;
  logic        btn_level, pulse, release_pulse;
  logic [15:0] press_cnt;

  int n_chk = 0, n_pass = 0;
  int cyc = 0;
  int npulse = 0, nrel = 0, nviol = 0;
  int pulse_q[$];
  logic prev_p = 1'b0, prev_r = 1'b0;
  int c0;

  btn_pulse_gen #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_in       (btn_in),
    .btn_level    (btn_level),
    .pulse        (pulse),
    .release_pulse(release_pulse),
    .press_cnt    (press_cnt)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  // strobe monitor: logs pulse times and flags overlap / back-to-back strobes
  always @(negedge clk) begin
    if (pulse) begin
      npulse++;
      pulse_q.push_back(cyc);
    end
    if (release_pulse) nrel++;
    if (pulse && release_pulse) nviol++;
    if (pulse && prev_p) nviol++;
    if (release_pulse && prev_r) nviol++;
    prev_p = pulse;
    prev_r = release_pulse;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // advance to just after the next n falling edges
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    rst    = 1'b1;
    btn_in = 1'b0;
    step(3);
    chk("rst_level", btn_level, 0);
    chk("rst_pulse", pulse, 0);
    chk("rst_rel", release_pulse, 0);
    chk("rst_cnt", press_cnt, 0);
    rst = 1'b0;
    step(2);

    // clean press: pulse in the cycle after edge k+5
    btn_in = 1'b1;
    c0 = cyc;
    step(5);
    chk("t1_early", pulse, 0);
    step(1);
    chk("t1_pulse", pulse, 1);
    chk("t1_level", btn_level, 1);
    chk("t1_cnt", press_cnt, 1);
    chk("t1_lat", pulse_q[0], c0 + 6);
    step(1);
    chk("t1_single", pulse, 0);

    // one-cycle low glitch while held: no release
    btn_in = 1'b0;
    step(1);
    btn_in = 1'b1;
    step(3);
    chk("t3_glitch_rel", nrel, 0);
    chk("t3_glitch_level", btn_level, 1);
    chk("t3_glitch_pulses", npulse, 1);

    // real release
    btn_in = 1'b0;
    step(5);
    chk("t3_rel_early", release_pulse, 0);
    step(1);
    chk("t3_rel", release_pulse, 1);
    chk("t3_rel_level", btn_level, 0);
    step(1);
    chk("t3_rel_single", release_pulse, 0);
    chk("t3_rel_count", nrel, 1);

    // bounce 1,0,1,1,0 then steady low: rejected
    btn_in = 1'b1; step(1);
    btn_in = 1'b0; step(1);
    btn_in = 1'b1; step(1);
    btn_in = 1'b1; step(1);
    btn_in = 1'b0; step(1);
    step(10);
    chk("t2_pulses", npulse, 1);
    chk("t2_level", btn_level, 0);
    chk("t2_cnt", press_cnt, 1);

    // reset during PRESS_WAIT (cnt=2), button held through reset
    btn_in = 1'b1;
    step(4);
    rst = 1'b1;
    #1;
    chk("t4_rst_cnt", press_cnt, 0);
    chk("t4_rst_level", btn_level, 0);
    chk("t4_rst_pulse", pulse, 0);
    step(2);
    pulse_q.delete();
    rst = 1'b0;
    c0 = cyc;
    step(5);
    chk("t4_early", pulse, 0);
    step(1);
    chk("t4_pulse", pulse, 1);
    chk("t4_level", btn_level, 1);
    chk("t4_cnt", press_cnt, 1);

    // keep holding: auto-repeat behaviour
    step(21);
    chk("t4_lat", pulse_q[0], c0 + 6);
`ifdef AUTO_REPEAT_EN
    begin
      int exp_off[5] = '{8, 11, 14, 17, 20};
      chk("t6_npulse", pulse_q.size(), 6);
      for (int i = 0; i < 5; i++)
        if (pulse_q.size() > i + 1)
          chk($sformatf("t6_rep%0d", i), pulse_q[i+1] - pulse_q[0], exp_off[i]);
      chk("t6_cnt", press_cnt, 6);
    end
`else
    chk("t6_npulse", pulse_q.size(), 1);
    chk("t6_cnt", press_cnt, 1);
`endif
    btn_in = 1'b0;
    step(8);
    chk("t6_rel_level", btn_level, 0);

    // counter wrap 0xFFFF -> 0x0000
    force dut.r_press_cnt = 16'hFFFF;
    step(1);
    release dut.r_press_cnt;
    step(1);
    chk("t5_pre", press_cnt, 16'hFFFF);
    btn_in = 1'b1;
    step(6);
    chk("t5_pulse", pulse, 1);
    chk("t5_wrap", press_cnt, 16'h0000);
    step(1);
    chk("t5_single", pulse, 0);
    btn_in = 1'b0;
    step(8);

    chk("strobe_rules", nviol, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
